// File: rtl/irrigacao_pkg.sv
// rtl/irrigacao_pkg.sv - humidity code and debounce state types shared with the display decoder
package irrigacao_pkg;

  typedef enum logic [1:0] {
    UMID_OK     = 2'b00,
    AREA0_SECA  = 2'b01,
    AREA1_SECA  = 2'b10,
    AMBAS_SECAS = 2'b11
  } umidade_t;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one area: 2-flop synchronizer, debounce FSM/counter and the debounced bit
module debounce_bit
  import irrigacao_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic u_o,
  output logic u_next_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1_q;
  logic          s_q;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          u_q, u_d;
  logic          last_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      u_q     <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
    end
  end

  // This disagreeing sample would bring the run length up to DEBOUNCE.
  assign last_sample = (int'(cnt_q) + 1) >= DEBOUNCE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    if (!enable_i) begin
      state_d = STABLE;
      cnt_d   = '0;
    end else if (tick_i) begin
      case (state_q)
        STABLE: begin
          cnt_d = '0;
          if (s_q != u_q) begin
            if (DEBOUNCE == 1) begin
              u_d = ~u_q;
            end else begin
              state_d = PENDING;
              cnt_d   = CW'(1);
            end
          end
        end
        PENDING: begin
          if (s_q == u_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (last_sample) begin
            u_d     = ~u_q;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign u_o      = u_q;
  assign u_next_o = u_d;

endmodule

// File: rtl/umidade_sensor_debounce.sv
// rtl/umidade_sensor_debounce.sv - sample prescaler, two debounced areas and the U change strobe
module umidade_sensor_debounce
  import irrigacao_pkg::*;
#(
  parameter int CLK_DIV  = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] raw_dry,
  output umidade_t   U,
  output logic       u_change,
  output logic       tick
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          u_change_q, u_change_d;
  logic [1:0]    u_bits;
  logic [1:0]    u_next;
  logic          wrap;

  assign wrap = (presc_q == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      u_change_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      u_change_q <= u_change_d;
    end
  end

  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (enable) begin
      tick_d  = wrap;
      presc_d = wrap ? '0 : presc_q + PW'(1);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_area
    debounce_bit #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable_i(enable),
      .tick_i  (tick_q),
      .raw_i   (raw_dry[i]),
      .u_o     (u_bits[i]),
      .u_next_o(u_next[i])
    );
  end

  // Compare whole vectors so a simultaneous two-area flip gives one strobe.
  assign u_change_d = (u_next != u_bits);

  assign U        = umidade_t'(u_bits);
  assign u_change = u_change_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_umidade_sensor_debounce.sv
// tb/tb_umidade_sensor_debounce.sv - directed self-checking bench for umidade_sensor_debounce
module tb_umidade_sensor_debounce;
  import irrigacao_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] raw_dry;
  umidade_t   U;
  logic       u_change;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int chg_cyc = 0;
  int uc_cnt = 0;

  umidade_sensor_debounce #(
    .CLK_DIV (4),
    .DEBOUNCE(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .raw_dry (raw_dry),
    .U       (U),
    .u_change(u_change),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (u_change === 1'b1) uc_cnt <= uc_cnt + 1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_raw(input logic [1:0] v);
    raw_dry = v;
    chg_cyc = cyc;
  endtask

  // Waits for n ticks whose sample already sees the synchronized new raw value.
  task automatic wait_qticks(input int n, input logic [1:0] old_u, output int used, output int bad);
    int got;
    got  = 0;
    used = 0;
    bad  = 0;
    while (got < n && used < 200) begin
      step();
      used++;
      if (U !== old_u) bad++;
      if (tick === 1'b1 && (cyc - chg_cyc) >= 2) got++;
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL wait_ticks: got %0d ticks, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    int prev, nticks, uc0;
    rst_n = 1'b0; enable = 1'b1; raw_dry = 2'b00;
    repeat (3) step();
    checks++;
    if (U !== 2'b00 || u_change !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: U=%b u_change=%b tick=%b, required 00 0 0", U, u_change, tick);
    end
    rst_n = 1'b1;
    apply_raw(2'b00);
    uc0 = uc_cnt; prev = -1; nticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick === 1'b1) begin
        if (prev >= 0) begin
          checks++;
          if (i - prev !== 4) begin
            errors++;
            $display("FAIL tick_period: %0d cycles, required 4", i - prev);
          end
        end
        prev = i; nticks++;
      end
    end
    checks++;
    if (nticks < 9 || U !== 2'b00 || uc_cnt !== uc0) begin
      errors++;
      $display("FAIL idle: ticks=%0d U=%b strobes=%0d, required >=9 00 0", nticks, U, uc_cnt - uc0);
    end
  endtask

  task automatic test_area0_dry();
    int used, bad, uc0;
    uc0 = uc_cnt;
    apply_raw(2'b01);
    wait_qticks(3, 2'b00, used, bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL area0_early: %0d early cycles, required 0", bad);
    end
    step();
    checks++;
    if (U !== 2'b01 || u_change !== 1'b1) begin
      errors++;
      $display("FAIL area0_flip: U=%b u_change=%b, required 01 1", U, u_change);
    end
    step();
    checks++;
    if (u_change !== 1'b0 || uc_cnt - uc0 !== 1) begin
      errors++;
      $display("FAIL area0_pulse: u_change=%b strobes=%0d, required 0 1", u_change, uc_cnt - uc0);
    end
    apply_raw(2'b00);
    wait_qticks(3, 2'b01, used, bad);
    step();
    checks++;
    if (bad !== 0 || U !== 2'b00 || u_change !== 1'b1) begin
      errors++;
      $display("FAIL area0_return: early=%0d U=%b u_change=%b, required 0 00 1", bad, U, u_change);
    end
  endtask

  task automatic test_glitch();
    int used, bad, uc0;
    uc0 = uc_cnt;
    apply_raw(2'b10);
    wait_qticks(2, 2'b00, used, bad);
    apply_raw(2'b00);
    repeat (20) begin
      step();
      if (U !== 2'b00) bad++;
    end
    checks++;
    if (bad !== 0 || uc_cnt !== uc0) begin
      errors++;
      $display("FAIL glitch: bad=%0d strobes=%0d, required 0 0", bad, uc_cnt - uc0);
    end
    // A fresh disturbance must again need the full three ticks.
    apply_raw(2'b10);
    wait_qticks(2, 2'b00, used, bad);
    step();
    checks++;
    if (bad !== 0 || U !== 2'b00) begin
      errors++;
      $display("FAIL glitch_count_cleared: bad=%0d U=%b, required 0 00", bad, U);
    end
    wait_qticks(1, 2'b00, used, bad);
    step();
    checks++;
    if (U !== 2'b10) begin
      errors++;
      $display("FAIL area1_flip: U=%b, required 10", U);
    end
    apply_raw(2'b00);
    wait_qticks(3, 2'b10, used, bad);
    step();
  endtask

  task automatic test_simultaneous();
    int used, bad, uc0;
    uc0 = uc_cnt;
    apply_raw(2'b11);
    wait_qticks(3, 2'b00, used, bad);
    step();
    checks++;
    if (bad !== 0 || U !== 2'b11 || u_change !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous: early=%0d U=%b u_change=%b, required 0 11 1", bad, U, u_change);
    end
    step();
    checks++;
    if (uc_cnt - uc0 !== 1) begin
      errors++;
      $display("FAIL simultaneous_pulses: %0d, required 1", uc_cnt - uc0);
    end
    apply_raw(2'b00);
    wait_qticks(3, 2'b11, used, bad);
    step();
    checks++;
    if (U !== 2'b00) begin
      errors++;
      $display("FAIL simultaneous_return: U=%b, required 00", U);
    end
  endtask

  task automatic test_disable();
    int used, bad, uc0;
    uc0 = uc_cnt;
    apply_raw(2'b01);
    wait_qticks(2, 2'b00, used, bad);
    enable = 1'b0;
    repeat (10) begin
      step();
      if (U !== 2'b00 || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || uc_cnt !== uc0) begin
      errors++;
      $display("FAIL disabled: bad=%0d strobes=%0d, required 0 0", bad, uc_cnt - uc0);
    end
    enable = 1'b1;
    wait_qticks(1, 2'b00, used, bad);
    checks++;
    if (used !== 4) begin
      errors++;
      $display("FAIL reenable_tick: %0d cycles, required 4", used);
    end
    wait_qticks(2, 2'b00, used, bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reenable_fresh: %0d early cycles, required 0", bad);
    end
    step();
    checks++;
    if (U !== 2'b01) begin
      errors++;
      $display("FAIL reenable_flip: U=%b, required 01", U);
    end
    apply_raw(2'b00);
    wait_qticks(3, 2'b01, used, bad);
    step();
  endtask

  task automatic test_async_reset();
    int used, bad;
    apply_raw(2'b11);
    wait_qticks(3, 2'b00, used, bad);
    step();
    checks++;
    if (U !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset: U=%b, required 11", U);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (U !== 2'b00 || u_change !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: U=%b u_change=%b, required 00 0", U, u_change);
    end
    step();
    rst_n = 1'b1;
    chg_cyc = cyc;
    wait_qticks(3, 2'b00, used, bad);
    step();
    checks++;
    if (bad !== 0 || U !== 2'b11) begin
      errors++;
      $display("FAIL post_reset: early=%0d U=%b, required 0 11", bad, U);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; raw_dry = 2'b00;
    test_reset();
    test_area0_dry();
    test_glitch();
    test_simultaneous();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
